// File: rtl/lsu_subword_if.sv
// Request/response channel between the pipeline MEM stage and lsu_subword.
// master = pipeline side (issues requests), slave = load/store unit.
interface lsu_subword_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_subword.sv
// lsu_subword: byte/halfword/word load-store unit in front of a word-only
// datamem. Sub-word stores are read-modify-write; loads are lane-extracted
// and sign/zero-extended. Optional performance counters: define LSU_PERF_EN.
module lsu_subword #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_subword_if.slave     bus,
  output logic             MemWrite,
  output logic             MemRead,
  output logic [31:0]      Address,
  output logic [31:0]      WriteData_Mem,
  input  logic [31:0]      ReadData_Mem,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE = 2'b00, RD = 2'b01, WR = 2'b10, RESP = 2'b11} state_t;

  state_t      state_r, nextState_s;
  logic        we_r, unsigned_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r;
  logic        respValid_r, respErr_r;
  logic [31:0] respRdata_r;
  logic        accept_s, reqBad_s;

  // size 11 is illegal; halfword/word must be naturally aligned
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // pick the addressed little-endian lane and extend it to 32 bits
  function automatic logic [31:0] extractLane(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic isUnsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = isUnsigned ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = isUnsigned ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // replace only the addressed lane of the old word with the store data
  function automatic logic [31:0] mergeLane(input logic [31:0] word, input logic [31:0] data,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    r[7:0]   = data[7:0];
          2'd1:    r[15:8]  = data[7:0];
          2'd2:    r[23:16] = data[7:0];
          default: r[31:24] = data[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) r[31:16] = data[15:0];
        else         r[15:0]  = data[15:0];
      end
      default: r = data;
    endcase
    return r;
  endfunction

  assign accept_s = bus.req_valid & bus.req_ready;
  assign reqBad_s = misaligned(bus.req_size, bus.req_addr[1:0]);

  // state register; async reset abandons any in-flight access immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= nextState_s;
  end

  // next-state: bad requests skip memory, word stores skip the read
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s)               nextState_s = IDLE;
        else if (reqBad_s)           nextState_s = RESP;
        else if (!bus.req_we)        nextState_s = RD;
        else if (bus.req_size == 2'b10) nextState_s = WR;
        else                         nextState_s = RD;
      end
      RD: begin
        if (we_r) nextState_s = WR;
        else      nextState_s = RESP;
      end
      WR:      nextState_s = RESP;
      RESP:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // request latch, RMW merge and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r        <= 1'b0;
      unsigned_r  <= 1'b0;
      size_r      <= 2'b00;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      respValid_r <= 1'b0;
      respErr_r   <= 1'b0;
      respRdata_r <= 32'h0000_0000;
    end else begin
      respValid_r <= (nextState_s == RESP);
      if (accept_s) begin
        we_r       <= bus.req_we;
        unsigned_r <= bus.req_unsigned;
        size_r     <= bus.req_size;
        addr_r     <= bus.req_addr;
        wdata_r    <= bus.req_wdata;
      end
      // wdata_r becomes the full word to write once the old word is known
      if (state_r == RD && we_r) begin
        wdata_r <= mergeLane(ReadData_Mem, wdata_r, size_r, addr_r[1:0]);
      end
      if (nextState_s == RESP) begin
        if (state_r == IDLE) begin
          respErr_r   <= 1'b1;
          respRdata_r <= 32'h0000_0000;
        end else if (state_r == RD) begin
          respErr_r   <= 1'b0;
          respRdata_r <= extractLane(ReadData_Mem, size_r, addr_r[1:0], unsigned_r);
        end else begin
          respErr_r   <= 1'b0;
          respRdata_r <= 32'h0000_0000;
        end
      end
    end
  end

  assign bus.req_ready  = (state_r == IDLE);
  assign bus.resp_valid = respValid_r;
  assign bus.resp_err   = respErr_r;
  assign bus.resp_rdata = respRdata_r;

  // strobes decode straight from the state flops so they cannot glitch
  assign MemRead       = (state_r == RD);
  assign MemWrite      = (state_r == WR);
  assign Address       = (MemRead | MemWrite) ? {addr_r[31:2], 2'b00} : 32'h0000_0000;
  assign WriteData_Mem = MemWrite ? wdata_r : 32'h0000_0000;

`ifdef LSU_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] loadCnt_r, storeCnt_r, errCnt_r;

  // saturating counters, bumped on the edge a response is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loadCnt_r  <= {CNT_W{1'b0}};
      storeCnt_r <= {CNT_W{1'b0}};
      errCnt_r   <= {CNT_W{1'b0}};
    end else if (nextState_s == RESP) begin
      if (state_r == IDLE) begin
        if (errCnt_r != CNT_MAX) errCnt_r <= errCnt_r + CNT_ONE;
      end else if (we_r) begin
        if (storeCnt_r != CNT_MAX) storeCnt_r <= storeCnt_r + CNT_ONE;
      end else begin
        if (loadCnt_r != CNT_MAX) loadCnt_r <= loadCnt_r + CNT_ONE;
      end
    end
  end

  assign load_cnt  = loadCnt_r;
  assign store_cnt = storeCnt_r;
  assign err_cnt   = errCnt_r;
`else
  assign load_cnt  = {CNT_W{1'b0}};
  assign store_cnt = {CNT_W{1'b0}};
  assign err_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_lsu_subword.sv
// Self-checking bench for lsu_subword: directed scenarios plus randomized
// traffic against a byte-level reference memory model.
module tb_lsu_subword;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             MemWrite, MemRead;
  logic [31:0]      Address, WriteData_Mem, ReadData_Mem;
  logic [CNT_W-1:0] load_cnt, store_cnt, err_cnt;

  lsu_subword_if bus();

  lsu_subword #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .MemWrite(MemWrite), .MemRead(MemRead), .Address(Address),
    .WriteData_Mem(WriteData_Mem), .ReadData_Mem(ReadData_Mem),
    .load_cnt(load_cnt), .store_cnt(store_cnt), .err_cnt(err_cnt)
  );

  // datamem stand-in: 16 words, combinational read, clocked write
  logic [31:0] mem [0:15];
  assign ReadData_Mem = MemRead ? mem[Address[5:2]] : 32'h0000_0000;
  always @(posedge clk) begin
    if (MemWrite) mem[Address[5:2]] <= WriteData_Mem;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] refMem [0:15];
  int nLoads, nStores, nErrs;
  int errCount, chkCount;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkResetVals(input string tag);
    checkVal({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    checkVal({tag, "_rvalid"}, 32'(bus.resp_valid), 32'd0);
    checkVal({tag, "_rerr"}, 32'(bus.resp_err), 32'd0);
    checkVal({tag, "_rdata"}, bus.resp_rdata, 32'h0);
    checkVal({tag, "_memrd"}, 32'(MemRead), 32'd0);
    checkVal({tag, "_memwr"}, 32'(MemWrite), 32'd0);
    checkVal({tag, "_addr"}, Address, 32'h0);
    checkVal({tag, "_wdata"}, WriteData_Mem, 32'h0);
    checkVal({tag, "_cnts"}, 32'(load_cnt) + 32'(store_cnt) + 32'(err_cnt), 32'd0);
  endtask

  // issue one request (called at a negedge) and check everything about it
  task automatic doReq(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] gotData);
    logic [31:0] old, mask, expData, expWord, wrSeen;
    logic expErr, gotErr, leak;
    int bytes, sh, expLat, expRd, expWr, lat, rdN, wrN;

    bytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    expErr = (size == 2'd3) || ((int'(addr[1:0]) % bytes) != 0);
    sh     = int'(addr[1:0]) * 8;
    old    = refMem[addr[5:2]];
    mask   = ((bytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (bytes * 8)) - 32'h1)) << sh;
    expData = 32'h0;
    expWord = old;
    if (expErr) begin
      expLat = 1; expRd = 0; expWr = 0; nErrs++;
    end else if (!we) begin
      expLat = 2; expRd = 1; expWr = 0; nLoads++;
      expData = (old & mask) >> sh;
      if (!uns && bytes < 4 && expData[bytes*8-1]) expData = expData | ~(mask >> sh);
    end else begin
      expRd = (bytes == 4) ? 0 : 1; expWr = 1; expLat = 2 + expRd; nStores++;
      expWord = (old & ~mask) | ((wdata << sh) & mask);
      refMem[addr[5:2]] = expWord;
    end

    checkVal({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    @(negedge clk);
    // request inputs must be ignored once accepted
    bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_size = 2'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_unsigned = ~uns;

    lat = 0; rdN = 0; wrN = 0; leak = 1'b0; wrSeen = 32'h0; gotErr = 1'b0; gotData = 32'h0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      if (MemRead) rdN++;
      if (MemWrite) begin wrN++; wrSeen = WriteData_Mem; end
      if ((MemRead || MemWrite) && Address !== {addr[31:2], 2'b00}) leak = 1'b1;
      if (!MemRead && !MemWrite && (Address !== 32'h0 || WriteData_Mem !== 32'h0)) leak = 1'b1;
      if (bus.resp_valid) begin
        lat = c; gotData = bus.resp_rdata; gotErr = bus.resp_err;
      end else begin
        @(negedge clk);
      end
    end
    checkVal({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkVal({tag, "_rdcyc"}, 32'(rdN), 32'(expRd));
    checkVal({tag, "_wrcyc"}, 32'(wrN), 32'(expWr));
    if (expWr == 1) checkVal({tag, "_wrword"}, wrSeen, expWord);
    checkVal({tag, "_err"}, 32'(gotErr), 32'(expErr));
    checkVal({tag, "_rdata"}, gotData, expData);
    checkVal({tag, "_busidle"}, 32'(leak), 32'd0);
    @(negedge clk);
    checkVal({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
    checkVal({tag, "_hold"}, bus.resp_rdata, gotData);
  endtask

  logic [31:0] got;
  logic        wrLeak;

  initial begin
    errCount = 0; chkCount = 0; nLoads = 0; nStores = 0; nErrs = 0;
    for (int i = 0; i < 16; i++) begin mem[i] = 32'h0; refMem[i] = 32'h0; end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetVals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // scenario 1
    doReq("sw0", 1'b1, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, got);
    doReq("lw0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, got);
    checkVal("lw0_val", got, 32'hDEAD_BEEF);
    // scenario 2
    doReq("lb3", 1'b0, 2'b00, 1'b0, 32'h3, 32'h0, got);
    checkVal("lb3_val", got, 32'hFFFF_FFDE);
    doReq("lbu3", 1'b0, 2'b00, 1'b1, 32'h3, 32'h0, got);
    checkVal("lbu3_val", got, 32'h0000_00DE);
    doReq("lh0", 1'b0, 2'b01, 1'b0, 32'h0, 32'h0, got);
    checkVal("lh0_val", got, 32'hFFFF_BEEF);
    doReq("lhu2", 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, got);
    checkVal("lhu2_val", got, 32'h0000_DEAD);
    // scenario 3
    doReq("sh2", 1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_1234, got);
    doReq("lw0b", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, got);
    checkVal("lw0b_val", got, 32'h1234_BEEF);
    doReq("sb0", 1'b1, 2'b00, 1'b0, 32'h0, 32'h0000_00A5, got);
    doReq("lw0c", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, got);
    checkVal("lw0c_val", got, 32'h1234_BEA5);
    // scenario 4
    doReq("lw6", 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, got);
    doReq("sh1", 1'b1, 2'b01, 1'b0, 32'h1, 32'hFFFF, got);
    doReq("sz3", 1'b0, 2'b11, 1'b0, 32'h4, 32'h0, got);
    // scenario 6 (counters after scenarios 1-4)
`ifdef LSU_PERF_EN
    checkVal("cnt_load", 32'(load_cnt), 32'd7);
    checkVal("cnt_store", 32'(store_cnt), 32'd3);
    checkVal("cnt_err", 32'(err_cnt), 32'd3);
`else
    checkVal("cnt_load", 32'(load_cnt), 32'd0);
    checkVal("cnt_store", 32'(store_cnt), 32'd0);
    checkVal("cnt_err", 32'(err_cnt), 32'd0);
`endif

    // scenario 5: reset while the RMW read is in flight
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0000_00FF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkVal("s5_inrd", 32'(MemRead), 32'd1);
    rst_n = 1'b0;
    #1;
    checkResetVals("s5_rst");
    wrLeak = 1'b0;
    repeat (2) begin @(negedge clk); if (MemWrite) wrLeak = 1'b1; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (MemWrite) wrLeak = 1'b1; end
    checkVal("s5_nowrite", 32'(wrLeak), 32'd0);
    nLoads = 0; nStores = 0; nErrs = 0;
    doReq("s5_lw0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, got);
    checkVal("s5_lw0_val", got, 32'h1234_BEA5);

    // randomized traffic
    for (int t = 0; t < 250; t++) begin
      doReq("rnd", 1'($urandom), 2'($urandom), 1'($urandom),
            32'($urandom_range(0, 63)), $urandom, got);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef LSU_PERF_EN
    checkVal("rnd_cnt_load", 32'(load_cnt), 32'(nLoads));
    checkVal("rnd_cnt_store", 32'(store_cnt), 32'(nStores));
    checkVal("rnd_cnt_err", 32'(err_cnt), 32'(nErrs));
`else
    checkVal("rnd_cnt_sum", 32'(load_cnt) + 32'(store_cnt) + 32'(err_cnt), 32'd0);
`endif
    for (int i = 0; i < 16; i++) checkVal("memimg", mem[i], refMem[i]);

    $display("Result: errors=%0d of %0d checks", errCount, chkCount);
    $finish;
  end

  // absolute time limit in case the run wedges
  initial begin
    #500000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/lsu_subword.md
Name: lsu_subword

Overview:
- Load/store unit sitting directly upstream of datamem in the MEM stage.
- Accepts byte, halfword and word load/store requests from the pipeline through a valid/ready handshake.
- Drives datamem's word-only port: MemWrite, MemRead, Address, WriteData_Mem, ReadData_Mem.
- Sub-word stores are done as read-modify-write; loads are lane-extracted and sign/zero-extended.

Parameters:
- CNT_W, 16: width of the performance counters (used only with LSU_PERF_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal request; valid with resp_valid.
- MemWrite  out  1  datamem write enable.
- MemRead  out  1  datamem read enable.
- Address  out  32  word-aligned address, {req_addr[31:2],2'b00}.
- WriteData_Mem  out  32  word written to datamem.
- ReadData_Mem  in  32  datamem read data, combinational on Address when MemRead=1.
- load_cnt, store_cnt, err_cnt  out  CNT_W each  performance counters.

Behaviour:
- One clock (clk); reset rst_n is asynchronous and active-low. These are fixed.
- Reset values:
  - state = IDLE; req_ready = 1.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - MemRead = 0, MemWrite = 0, Address = 0, WriteData_Mem = 0.
  - All counters = 0.
- FSM states: IDLE, RD, WR, RESP.
  - MemRead and MemWrite are decoded from the state register only, so they are glitch-free.
- Accept: when req_valid && req_ready at a rising edge, the request is latched into internal registers and the FSM leaves IDLE. Request inputs are ignored in every other state.
- Alignment check at accept:
  - Halfword requires addr[0] = 0; word requires addr[1:0] = 0; size 11 is always illegal.
  - Failure: go to RESP with resp_err = 1 and resp_rdata = 0. MemRead and MemWrite are never asserted.
- Load: IDLE -> RD -> RESP.
  - In RD, MemRead = 1 and Address = aligned address.
  - At the end of RD, ReadData_Mem is captured, the lane is selected, extended and registered into resp_rdata.
  - resp_valid rises 2 cycles after the accept edge.
- Store word: IDLE -> WR -> RESP.
  - In WR, MemWrite = 1 and WriteData_Mem = req_wdata.
- Store byte/halfword: IDLE -> RD -> WR -> RESP.
  - RD reads the old word. WR writes the merged word: only the addressed lane is replaced by req_wdata[7:0] or req_wdata[15:0].
  - resp_valid rises 3 cycles after accept.
- Byte lanes are little-endian:
  - addr[1:0] = 0 selects bits [7:0]; addr[1:0] = 3 selects bits [31:24].
  - Halfword addr[1] = 1 selects bits [31:16].
- RESP: resp_valid = 1 for exactly one cycle, then IDLE with req_ready = 1.
  - No back-pressure on the response side.
  - Minimum request spacing is 2 cycles.
- resp_rdata and resp_err hold their value until the next response. resp_rdata is cleared to 0 on store responses.
- Address and WriteData_Mem are 0 whenever MemRead and MemWrite are both 0.
- Reset mid-operation (rst_n low in RD or WR): the FSM returns to IDLE immediately and MemWrite drops asynchronously. No partial write is issued after reset, and the pending request is discarded without a response.

Optional Feature:
- Macro: LSU_PERF_EN.
- Defined:
  - load_cnt increments on each successful load response.
  - store_cnt increments on each successful store response.
  - err_cnt increments on each resp_err response.
  - All counters saturate at 2^CNT_W-1.
- Undefined: the counters are tied to 0 and no counter flops are inferred.

Test Plan:
1. SW addr 0x0 data 0xDEADBEEF, then LW 0x0 -> resp_rdata = 0xDEADBEEF; resp_valid 2 cycles after accept; exactly one MemWrite cycle for the store.
2. LB 0x3 -> 0xFFFFFFDE. LBU 0x3 -> 0x000000DE. LH 0x0 -> 0xFFFFBEEF. LHU 0x2 -> 0x0000DEAD.
3. SH 0x2 data 0x00001234 -> one RD cycle then one WR cycle with WriteData_Mem = 0x1234BEEF; LW 0x0 -> 0x1234BEEF. Then SB 0x0 data 0xA5 -> LW 0x0 = 0x1234BEA5.
4. LW 0x6, SH 0x1 and size 11 -> each gives resp_err = 1, resp_rdata = 0, resp_valid 1 cycle after accept; MemRead and MemWrite stay 0 throughout.
5. SB 0x0 data 0xFF, rst_n pulsed low during RD -> MemWrite never asserted; after reset, LW 0x0 still = 0x1234BEA5; all outputs read their reset values while rst_n is low.
6. With LSU_PERF_EN: the sequence from scenarios 1-4 -> load_cnt = 7, store_cnt = 3, err_cnt = 3. Without the macro: all counters = 0.
